// File: rtl/mem_req_arbiter_if.sv
// Requester and mem-side signal bundle for mem_req_arbiter; master is the arbiter view.
// Single-cycle combinational accept on req_ready_o, valid_o held until ready_i; no response backpressure.
interface mem_req_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 6
);
   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0]            req_wr_rd_i;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
   logic [NUM_REQ*WIDTH-1:0]      req_wr_data_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ-1:0]            rsp_valid_o;
   logic [WIDTH-1:0]              rsp_rd_data_o;
   logic                          valid_o;
   logic                          wr_rd_o;
   logic [ADDR_WIDTH-1:0]         addr_o;
   logic [WIDTH-1:0]              wr_data_o;
   logic                          ready_i;
   logic [WIDTH-1:0]              rd_data_i;

   modport master (
      input  req_valid_i, req_wr_rd_i, req_addr_i, req_wr_data_i, ready_i, rd_data_i,
      output req_ready_o, rsp_valid_o, rsp_rd_data_o, valid_o, wr_rd_o, addr_o, wr_data_o
   );

   modport slave (
      output req_valid_i, req_wr_rd_i, req_addr_i, req_wr_data_i, ready_i, rd_data_i,
      input  req_ready_o, rsp_valid_o, rsp_rd_data_o, valid_o, wr_rd_o, addr_o, wr_data_o
   );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin merge of NUM_REQ requesters onto one mem port; accept is combinational, issue 1 cycle later, read
// response RD_LATENCY+1 after the mem handshake; holds requests until ready_i. MEM_ARB_STATS_EN adds grant counters.
module mem_req_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_req_arbiter_if.master     bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0] stat_grants_o
`endif
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef struct packed {
      logic                  wr_rd;
      logic [ADDR_WIDTH-1:0] addr;
      logic [WIDTH-1:0]      data;
   } req_t;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t          state, state_nxt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] grant_id;
   logic [ID_W-1:0] issue_id;
   logic            grant_vld;
   logic            load;
   req_t            req_sel;
   req_t            held;
   tag_t            tag_pipe [RD_LATENCY];
   tag_t            tag_out;
   logic            rd_push;

   // First valid requester at or above ptr, wrapping.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_vld && bus.req_valid_i[(int'(ptr) + i) % NUM_REQ]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'((int'(ptr) + i) % NUM_REQ);
         end
      end
   end

   always_comb begin
      req_sel.wr_rd = bus.req_wr_rd_i[grant_id];
      req_sel.addr  = bus.req_addr_i[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
      req_sel.data  = bus.req_wr_data_i[grant_id*WIDTH +: WIDTH];
   end

   always_comb begin
      state_nxt       = state;
      load            = 1'b0;
      bus.req_ready_o = '0;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               bus.req_ready_o[grant_id] = 1'b1;
               load                      = 1'b1;
               state_nxt                 = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         held     <= '0;
         issue_id <= '0;
      end else begin
         state <= state_nxt;
         if (load) begin
            held     <= req_sel;
            issue_id <= grant_id;
            ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
      end
   end

   assign bus.valid_o   = (state == ISSUE);
   assign bus.wr_rd_o   = held.wr_rd;
   assign bus.addr_o    = held.addr;
   assign bus.wr_data_o = held.data;

   assign rd_push = bus.valid_o && bus.ready_i && !held.wr_rd;
   assign tag_out = tag_pipe[RD_LATENCY-1];

   // Tag shifts alongside mem's read pipeline so it exits the cycle rd_data_i is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++) tag_pipe[i] <= '0;
      end else begin
         tag_pipe[0] <= '{vld: rd_push, id: issue_id};
         for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid_o   <= '0;
         bus.rsp_rd_data_o <= '0;
      end else begin
         bus.rsp_valid_o <= tag_out.vld ? (NUM_REQ'(1) << tag_out.id) : '0;
         if (tag_out.vld) bus.rsp_rd_data_o <= bus.rd_data_i;
      end
   end

`ifdef MEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grants_o <= '0;
      end else if (load && stat_grants_o[grant_id*16 +: 16] != 16'hFFFF) begin
         stat_grants_o[grant_id*16 +: 16] <= stat_grants_o[grant_id*16 +: 16] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: reset, write hold, round-robin, read routing, pointer skip, mid-op reset.
module tb_mem_req_arbiter;
   localparam int NR = 3;
   localparam int W  = 16;
   localparam int AW = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_req_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

`ifdef MEM_ARB_STATS_EN
   logic [NR*16-1:0] stat_grants;
`endif

   mem_req_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.master)
`ifdef MEM_ARB_STATS_EN
      ,
      .stat_grants_o (stat_grants)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic clear_reqs;
      bus.req_valid_i = '0;
   endtask

   task automatic idle_inputs;
      bus.req_valid_i   = '0;
      bus.req_wr_rd_i   = '0;
      bus.req_addr_i    = '0;
      bus.req_wr_data_i = '0;
      bus.ready_i       = 1'b0;
      bus.rd_data_i     = '0;
   endtask

   task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
      bus.req_valid_i[k]             = 1'b1;
      bus.req_wr_rd_i[k]             = wr;
      bus.req_addr_i[k*AW +: AW]     = a;
      bus.req_wr_data_i[k*W +: W]    = d;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      step;
      step;
      rst = 1'b0;
   endtask

   initial begin
      idle_inputs();
      do_reset();
      settle;
      check("rst_valid",   32'(bus.valid_o), 0);
      check("rst_ready",   32'(bus.req_ready_o), 0);
      check("rst_rsp_vld", 32'(bus.rsp_valid_o), 0);
      check("rst_rsp_dat", 32'(bus.rsp_rd_data_o), 0);
      check("rst_wr_rd",   32'(bus.wr_rd_o), 0);
      check("rst_addr",    32'(bus.addr_o), 0);
      check("rst_wdata",   32'(bus.wr_data_o), 0);

      // Write from requester 0 held while mem stalls
      set_req(0, 1'b1, 6'd5, 16'hABCD);
      settle;
      check("wr_ready", 32'(bus.req_ready_o), 32'b001);
      step;
      clear_reqs();
      for (int c = 0; c < 3; c++) begin
         settle;
         check("wr_hold_valid", 32'(bus.valid_o), 1);
         check("wr_hold_wr_rd", 32'(bus.wr_rd_o), 1);
         check("wr_hold_addr",  32'(bus.addr_o), 5);
         check("wr_hold_data",  32'(bus.wr_data_o), 32'hABCD);
         check("wr_hold_ready", 32'(bus.req_ready_o), 0);
         step;
      end
      bus.ready_i = 1'b1;
      settle;
      check("wr_valid_pre_hs", 32'(bus.valid_o), 1);
      step;
      settle;
      check("wr_valid_drop", 32'(bus.valid_o), 0);
      check("wr_no_rsp",     32'(bus.rsp_valid_o), 0);
      step;
      settle;
      check("wr_no_rsp2",    32'(bus.rsp_valid_o), 0);
      bus.ready_i = 1'b0;

      // Round-robin with all requesters valid and mem always ready
      do_reset();
      for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(k + 1), W'(16'h1000 + k));
      bus.ready_i = 1'b1;
      for (int g = 0; g < 6; g++) begin
         settle;
         check("rr_grant", 32'(bus.req_ready_o), 32'(1) << (g % NR));
         step;
         settle;
         check("rr_issue_valid", 32'(bus.valid_o), 1);
         check("rr_issue_addr",  32'(bus.addr_o), 32'((g % NR) + 1));
         check("rr_issue_noack", 32'(bus.req_ready_o), 0);
         step;
      end
      clear_reqs();

      // Read from requester 2 routed back after RD_LATENCY+1
      set_req(2, 1'b0, 6'd9, 16'h0000);
      settle;
      check("rd_grant", 32'(bus.req_ready_o), 32'b100);
      step;
      clear_reqs();
      settle;
      check("rd_valid", 32'(bus.valid_o), 1);
      check("rd_wr_rd", 32'(bus.wr_rd_o), 0);
      check("rd_addr",  32'(bus.addr_o), 9);
      step;
      bus.rd_data_i = 16'h1234;
      settle;
      check("rd_rsp_early", 32'(bus.rsp_valid_o), 0);
      step;
      bus.rd_data_i = '0;
      settle;
      check("rd_rsp_vld", 32'(bus.rsp_valid_o), 32'b100);
      check("rd_rsp_dat", 32'(bus.rsp_rd_data_o), 32'h1234);
      step;
      settle;
      check("rd_rsp_once", 32'(bus.rsp_valid_o), 0);

      // Pointer skip: grant 1, then with 0 and 2 waiting, 2 goes first
      set_req(1, 1'b1, 6'd1, 16'h0011);
      settle;
      check("skip_g1", 32'(bus.req_ready_o), 32'b010);
      step;
      clear_reqs();
      step;
      set_req(0, 1'b1, 6'd2, 16'h0022);
      set_req(2, 1'b1, 6'd3, 16'h0033);
      settle;
      check("skip_g2", 32'(bus.req_ready_o), 32'b100);
      step;
      bus.req_valid_i[2] = 1'b0;
      step;
      settle;
      check("skip_g3", 32'(bus.req_ready_o), 32'b001);
      step;
      clear_reqs();
      step;

      // Reset with a read tag in flight: its response must never appear
      set_req(2, 1'b0, 6'd4, 16'h0000);
      settle;
      check("mrb_grant", 32'(bus.req_ready_o), 32'b100);
      step;
      clear_reqs();
      settle;
      check("mrb_valid", 32'(bus.valid_o), 1);
      step;
      rst = 1'b1;
      bus.rd_data_i = 16'h7777;
      step;
      rst = 1'b0;
      bus.rd_data_i = '0;
      settle;
      check("mrb_no_rsp", 32'(bus.rsp_valid_o), 0);
      step;
      settle;
      check("mrb_no_rsp2", 32'(bus.rsp_valid_o), 0);

      // Reset coinciding with a pending read handshake
      bus.ready_i = 1'b0;
      set_req(1, 1'b0, 6'd3, 16'h0000);
      settle;
      check("mra_grant", 32'(bus.req_ready_o), 32'b010);
      step;
      clear_reqs();
      settle;
      check("mra_valid", 32'(bus.valid_o), 1);
      bus.ready_i = 1'b1;
      rst = 1'b1;
      step;
      rst = 1'b0;
      bus.ready_i = 1'b0;
      bus.rd_data_i = 16'h5555;
      settle;
      check("mra_valid_drop", 32'(bus.valid_o), 0);
      step;
      bus.rd_data_i = '0;
      settle;
      check("mra_no_rsp", 32'(bus.rsp_valid_o), 0);
      step;
      settle;
      check("mra_no_rsp2", 32'(bus.rsp_valid_o), 0);
      for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(k), W'(k));
      settle;
      check("mr_next_grant", 32'(bus.req_ready_o), 32'b001);
      step;
      clear_reqs();
      bus.ready_i = 1'b1;
      step;
      bus.ready_i = 1'b0;

`ifdef MEM_ARB_STATS_EN
      do_reset();
      bus.ready_i = 1'b1;
      for (int n = 0; n < 5; n++) begin
         set_req(1, 1'b1, 6'd7, 16'h0077);
         step;
         clear_reqs();
         step;
      end
      settle;
      check("stat_req1", 32'(stat_grants[31:16]), 5);
      check("stat_req0", 32'(stat_grants[15:0]), 0);
      check("stat_req2", 32'(stat_grants[47:32]), 0);
      do_reset();
      settle;
      check("stat_rst", 32'(stat_grants[31:16]), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Upstream neighbour of the `mem` block: merges NUM_REQ independent requester ports (one per agent) onto the single valid/ready request port of `mem`.
- Arbitration is round-robin. Each accepted request is registered and held toward `mem` until `ready_i`.
- Read data returning from `mem` is routed back to the requester that issued the read.

Parameters:
- NUM_REQ, 3, number of requester ports (≥2)
- WIDTH, 16, data width; matches mem WIDTH
- ADDR_WIDTH, 6, address width; matches mem ADDR_WIDTH
- RD_LATENCY, 1, cycles from the read handshake (valid_o && ready_i) to rd_data_i valid; ≥1

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_wr_rd_i  in  NUM_REQ  per-requester op; 1=write, 0=read
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester address; requester k in slice [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_wr_data_i  in  NUM_REQ*WIDTH  per-requester write data; slice [k*WIDTH +: WIDTH]
- req_ready_o  out  NUM_REQ  one-hot accept strobe
- rsp_valid_o  out  NUM_REQ  one-hot read-response strobe
- rsp_rd_data_o  out  WIDTH  read data; shared, qualified by rsp_valid_o
- valid_o  out  1  to mem valid_i
- wr_rd_o  out  1  to mem wr_rd_i
- addr_o  out  ADDR_WIDTH  to mem addr_i
- wr_data_o  out  WIDTH  to mem wr_data_i
- ready_i  in  1  from mem ready_o
- rd_data_i  in  WIDTH  from mem rd_data_o

Behaviour:
- Reset (rst=1 at posedge) clears:
  - all outputs to 0
  - FSM to IDLE
  - RR pointer to 0
  - read-tag pipeline
- Reset mid-operation:
  - valid_o drops the next cycle even if a handshake is pending; the held request is discarded.
  - In-flight read tags are discarded, so no rsp_valid_o is produced for them.
- FSM state IDLE:
  - If any req_valid_i is high, grant the first valid requester searching from the RR pointer upward, wrapping NUM_REQ-1 -> 0.
  - req_ready_o[grant] is asserted combinationally in that cycle; a requester handshake = req_valid_i[k] && req_ready_o[k].
  - Latch the granted op/addr/data into the output registers and set valid_o=1 the next cycle.
  - Set RR pointer = (grant+1) mod NUM_REQ.
  - Go to ISSUE.
  - If no requester is valid: stay in IDLE, req_ready_o all 0, pointer unchanged.
- FSM state ISSUE:
  - valid_o, wr_rd_o, addr_o and wr_data_o are held stable.
  - req_ready_o is all 0.
  - On valid_o && ready_i: valid_o drops the next cycle and the FSM returns to IDLE.
  - Peak throughput is one request per 2 cycles.
- Read return:
  - On a read handshake toward mem, push {1, grant_id} into an RD_LATENCY-deep shift pipeline; push {0, x} on every other cycle.
  - When the tag exits the pipeline (the cycle rd_data_i is valid), register it: next cycle rsp_valid_o[id]=1 for exactly 1 cycle and rsp_rd_data_o=rd_data_i.
  - Total read latency from the mem handshake to rsp_valid_o = RD_LATENCY+1.
  - There is no response backpressure.
- Writes produce no response.
- Requester rules:
  - A requester must hold req_valid_i and its payload stable until accepted.
  - Dropping req_valid_i before acceptance is legal, and that requester is simply not granted.
- Simultaneous events:
  - Requests arriving while in ISSUE wait for the next IDLE.
  - A read response can coincide with a new grant; the two paths are independent.
- Payload handling: address and data pass through unmodified; no width conversion.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - Adds output port stat_grants_o, NUM_REQ*16 bits.
  - One 16-bit saturating counter per requester, incremented on each grant to that requester and held at 16'hFFFF once reached.
  - Cleared by rst.
- Undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: after rst, all outputs 0. Requester 0 writes addr 5, data 16'hABCD. req_ready_o=3'b001 in the first IDLE cycle; valid_o=1, wr_rd_o=1, addr_o=5, wr_data_o=ABCD held while ready_i=0 for 3 cycles; valid_o drops 1 cycle after ready_i=1; no rsp_valid_o.
- Round-robin: all 3 requesters valid continuously, ready_i tied 1. Grant order 0,1,2,0,1,2; each grant 2 cycles apart.
- Read routing: requester 2 reads addr 9, mem returns 16'h1234 RD_LATENCY=1 cycle after the handshake. rsp_valid_o=3'b100 for 1 cycle, 2 cycles after the handshake, with rsp_rd_data_o=1234.
- Pointer skip: only requester 1 valid. It is granted; pointer becomes 2. Then requesters 0 and 2 are valid: requester 2 is granted first, then requester 0.
- Mid-operation reset: rst pulsed while valid_o=1 and a read tag is in flight. valid_o=0 the next cycle; no rsp_valid_o ever fires; the next grant goes to requester 0.
- MEM_ARB_STATS_EN: 5 grants to requester 1 -> stat_grants_o[31:16]=5; after rst, 0.
